pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Input-capture counterpart to the PWM output channel: measures the period and high time of an external PWM signal.
- Synchronises `pwm_in`, detects its edges, and counts clk cycles between them.
- Publishes period/high-time registers with a one-cycle valid strobe, plus edge and timeout event pulses for the peripheral's interrupt logic.
- Sits in the PWM peripheral alongside the output channels, read through the peripheral's register interface.

Parameters:
- WIDTH, 16, width of the internal counter and of the captured period/high-time values.

Ports:
- clk  input  1  system clock; only clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  capture enable; low forces IDLE.
- pwm_in  input  1  external PWM signal, asynchronous to clk.
- periodValue  output  WIDTH  last captured period, in clk cycles.
- highValue  output  WIDTH  last captured high time, in clk cycles.
- captureValid  output  1  one-cycle pulse when periodValue/highValue update.
- timeout  output  1  one-cycle pulse when the counter saturates without an edge.
- risingEdge  output  1  one-cycle pulse per detected rising edge (registered).
- fallingEdge  output  1  one-cycle pulse per detected falling edge (registered).
- pwmLevel  output  1  synchronised level of pwm_in.

Behaviour:
- Reset: all flops 0.
  - Outputs: periodValue=0, highValue=0, captureValid=0, timeout=0, risingEdge=0, fallingEdge=0, pwmLevel=0.
  - State=IDLE, counter=0.
- Synchroniser: two flops (sync0, sync1), then history flop lastLevel.
  - pwmLevel = sync1.
  - rise = sync1 & !lastLevel; fall = !sync1 & lastLevel.
  - pwm_in transition before clk edge t gives rise/fall during cycle t+2.
  - risingEdge/fallingEdge are registered, so they are visible in cycle t+3.
  - Synchroniser and edge pulses run regardless of enable.
- Counter:
  - On rise while enabled: counter <= 1.
  - Otherwise in HIGH/LOW: counter <= counter+1, saturating at all-ones.
  - In IDLE: counter <= 0.
- States:
  - IDLE: wait for rise, then go to HIGH.
  - HIGH: on fall, latch highShadow <= counter and go to LOW.
  - LOW: on rise, capture and go to HIGH.
- Capture, on the clock after rise in LOW:
  - periodValue <= counter; highValue <= highShadow; captureValid=1 for exactly that cycle.
  - Counter value at the rise equals cycles since the previous rise, so period P and high time H read exactly P and H.
- Timeout: in HIGH or LOW, counter == all-ones and no edge this cycle:
  - timeout pulse next cycle; go to IDLE; periodValue/highValue hold.
- Simultaneous events:
  - An edge in the same cycle as saturation wins; capture proceeds with period = all-ones and no timeout.
  - A fall in IDLE is ignored.
- First rise after IDLE only arms measurement; the first captureValid comes at the second rise.
- enable low:
  - State -> IDLE, counter -> 0.
  - Any in-progress measurement is discarded; no captureValid and no timeout.
  - periodValue/highValue hold.
- Re-enabling requires a fresh rise before the next capture.
- rst mid-measurement: everything returns to reset values on the next clock, including the synchroniser.
- Minimum measurable pulse is 1 cycle post-synchroniser (H=1).
  - Pulses narrower than one clk may be lost; no requirement on them.

Decomposition:
- No shared package needed.
- State encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2) as localparams in the module.
- One natural sub-module: pwm_input_sync.
  - Contents: 2-flop synchroniser + history flop + rise/fall decode.
  - Outputs: level, rise, fall.
  - Reusable for future PWM/timer capture inputs.

Test Plan:
- WIDTH=16, enable=1, pwm_in period 10 cycles / high 3 cycles, 4 periods.
  - First captureValid 1 cycle after the 2nd detected rise, with periodValue=10, highValue=3.
  - Then one pulse every 10 cycles, values unchanged.
- Sync latency: single pwm_in rise at cycle 0.
  - pwmLevel=1 from cycle 2; risingEdge pulse in cycle 3 only.
- WIDTH=8, pwm_in held high after one rise.
  - timeout pulse once, 255 counts after the rise; state IDLE.
  - No captureValid; previous periodValue/highValue retained.
- enable dropped mid-HIGH, restored 5 cycles later, then 2 periods of 20/8.
  - No capture from the aborted period.
  - Capture 20/8 at the 2nd rise after re-enable.
- 1-cycle-wide high pulses at period 4.
  - periodValue=4, highValue=1.
- rst asserted mid-LOW.
  - All outputs 0 the next cycle; the next capture requires two fresh rises.

Source files
------------

// File: rtl/pwm_input_sync.sv
// -----------------------------------------------------------------------------
// pwm_input_sync
//
// Brings an asynchronous PWM input into the clk domain and decodes its edges.
// Two flops form the synchroniser. A third history flop holds the previous
// synchronised level, which the combinational rise/fall decode compares
// against.
//
// Timing: a transition of pwm_i just before clk edge t is seen on level_o
// after edge t+1. rise_o/fall_o are high for the one cycle that follows.
//
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous, active-high reset; clears all three flops
//   pwm_i   - raw external PWM signal, asynchronous to clk_i
//   level_o - synchronised level (registered)
//   rise_o  - combinational one-cycle rise indication
//   fall_o  - combinational one-cycle fall indication
// -----------------------------------------------------------------------------
module pwm_input_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync0_q;
  logic sync1_q;
  logic last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sync0_q <= pwm_i;
      sync1_q <= sync0_q;
      last_q  <= sync1_q;
    end
  end

  assign level_o = sync1_q;
  assign rise_o  = sync1_q & ~last_q;
  assign fall_o  = ~sync1_q & last_q;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Input-capture channel of the PWM peripheral. It measures the period and the
// high time of an external PWM signal in clk cycles.
//
// The counter loads 1 on every enabled rise, so at the next rise it holds
// exactly the number of cycles since the previous rise. At each fall its value
// is the high time, which is parked in a shadow register. At the following
// rise both values are published together with a one-cycle captureValid
// strobe.
//
// The first rise after IDLE only arms the measurement. A counter that
// saturates with no edge produces a one-cycle timeout pulse and returns the
// FSM to IDLE. Published values are never cleared except by reset.
//
// captureValid, timeout, risingEdge and fallingEdge are single-cycle event
// strobes. They have no handshake and no backpressure: a consumer that needs
// them must sample them in the cycle they are high.
//
// Parameters:
//   WIDTH        - counter width and width of the captured values
// Ports:
//   clk          - system clock
//   rst          - synchronous, active-high reset
//   enable       - capture enable; low forces IDLE and discards a measurement
//   pwm_in       - external PWM signal, asynchronous to clk
//   periodValue  - last captured period (clk cycles)
//   highValue    - last captured high time (clk cycles)
//   captureValid - one-cycle pulse when periodValue/highValue update
//   timeout      - one-cycle pulse when the counter saturates without an edge
//   risingEdge   - registered one-cycle pulse per detected rising edge
//   fallingEdge  - registered one-cycle pulse per detected falling edge
//   pwmLevel     - synchronised level of pwm_in
//   dbgState     - current FSM state (IDLE=0, HIGH=1, LOW=2), for observation
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] periodValue,
  output logic [WIDTH-1:0] highValue,
  output logic             captureValid,
  output logic             timeout,
  output logic             risingEdge,
  output logic             fallingEdge,
  output logic             pwmLevel,
  output logic [1:0]       dbgState
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic             level;
  logic             rise;
  logic             fall;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] high_shadow_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] high_q;
  logic             capture_valid_q;
  logic             timeout_q;
  logic             rising_edge_q;
  logic             falling_edge_q;
  logic             count_sat;

  pwm_input_sync u_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .pwm_i   (pwm_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // Saturating increment. It holds at all-ones so that a fall or rise that
  // arrives in the saturation cycle still measures all-ones.
  assign count_sat = (count_q == CNT_MAX);
  assign count_d   = count_sat ? count_q : (count_q + CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      count_q         <= '0;
      high_shadow_q   <= '0;
      period_q        <= '0;
      high_q          <= '0;
      capture_valid_q <= 1'b0;
      timeout_q       <= 1'b0;
      rising_edge_q   <= 1'b0;
      falling_edge_q  <= 1'b0;
    end else begin
      // Edge strobes follow the synchroniser whatever the enable state is.
      rising_edge_q   <= rise;
      falling_edge_q  <= fall;
      capture_valid_q <= 1'b0;
      timeout_q       <= 1'b0;

      if (!enable) begin
        // Abandon any measurement silently. Published values stay as they are.
        state_q <= ST_IDLE;
        count_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // A fall here is ignored. Only a rise arms a measurement.
            if (rise) begin
              count_q <= CNT_ONE;
              state_q <= ST_HIGH;
            end else begin
              count_q <= '0;
            end
          end

          ST_HIGH: begin
            if (rise) begin
              count_q <= CNT_ONE;
            end else if (fall) begin
              high_shadow_q <= count_q;
              count_q       <= count_d;
              state_q       <= ST_LOW;
            end else if (count_sat) begin
              timeout_q <= 1'b1;
              count_q   <= '0;
              state_q   <= ST_IDLE;
            end else begin
              count_q <= count_d;
            end
          end

          ST_LOW: begin
            if (rise) begin
              period_q        <= count_q;
              high_q          <= high_shadow_q;
              capture_valid_q <= 1'b1;
              count_q         <= CNT_ONE;
              state_q         <= ST_HIGH;
            end else if (count_sat) begin
              timeout_q <= 1'b1;
              count_q   <= '0;
              state_q   <= ST_IDLE;
            end else begin
              count_q <= count_d;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  assign periodValue  = period_q;
  assign highValue    = high_q;
  assign captureValid = capture_valid_q;
  assign timeout      = timeout_q;
  assign risingEdge   = rising_edge_q;
  assign fallingEdge  = falling_edge_q;
  assign pwmLevel     = level;
  assign dbgState     = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed bench for pwm_capture. Two instances, with WIDTH=16 and WIDTH=8,
// share every input. Inputs change on the falling clock edge. Outputs are
// sampled 1 time unit after the rising edge.
//
// "Step s" means: drive the inputs before rising edge s, then sample after it.
// A pwm_in rise driven in step s is reported by risingEdge after step s+2. The
// counter loads 1 in step s+2, so a capture appears P steps after that rise's
// risingEdge.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pwm_in;

  logic [15:0] period16, high16;
  logic        cv16, to16, re16, fe16, lvl16;
  logic [1:0]  st16;
  logic [7:0]  period8, high8;
  logic        cv8, to8, re8, fe8, lvl8;
  logic [1:0]  st8;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b0;
  end

  pwm_capture #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
    .periodValue(period16), .highValue(high16), .captureValid(cv16),
    .timeout(to16), .risingEdge(re16), .fallingEdge(fe16),
    .pwmLevel(lvl16), .dbgState(st16)
  );

  pwm_capture #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
    .periodValue(period8), .highValue(high8), .captureValid(cv8),
    .timeout(to8), .risingEdge(re8), .fallingEdge(fe8),
    .pwmLevel(lvl8), .dbgState(st8)
  );

  // driver tasks
  task automatic step(input logic lvl, input logic en, input logic rs);
    @(negedge clk);
    pwm_in = lvl;
    enable = en;
    rst    = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);
  endtask

  // tests
  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (period16 !== 16'd0 || high16 !== 16'd0) begin
      errors++;
      $display("FAIL reset_values16: got %0d/%0d want 0/0", period16, high16);
    end
    checks++;
    if ({cv16, to16, re16, fe16, lvl16} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes16: got %b want 00000", {cv16, to16, re16, fe16, lvl16});
    end
    checks++;
    if (st16 !== 2'd0 || st8 !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d want 0/0", st16, st8);
    end
    checks++;
    if (period8 !== 8'd0 || high8 !== 8'd0 || {cv8, to8, re8, fe8, lvl8} !== 5'b0) begin
      errors++;
      $display("FAIL reset_values8: got %0d/%0d %b want 0/0 00000",
               period8, high8, {cv8, to8, re8, fe8, lvl8});
    end
    step(1'b0, 1'b1, 1'b0);
  endtask

  // Period 10, high 3, four periods. The rises are driven in steps 0, 10, 20
  // and 30, so captures appear after steps 12, 22 and 32.
  task automatic test_periodic();
    logic exp_cv;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      step((s % 10) < 3, 1'b1, 1'b0);
      exp_cv = (s == 12) || (s == 22) || (s == 32);
      checks++;
      if (cv16 !== exp_cv || cv8 !== exp_cv) begin
        errors++;
        $display("FAIL periodic_valid step %0d: got %b/%b want %b", s, cv16, cv8, exp_cv);
      end
      if (exp_cv) begin
        checks++;
        if (period16 !== 16'd10 || high16 !== 16'd3 || period8 !== 8'd10 || high8 !== 8'd3) begin
          errors++;
          $display("FAIL periodic_values step %0d: got %0d/%0d %0d/%0d want 10/3",
                   s, period16, high16, period8, high8);
        end
      end
      if (s == 2) begin
        checks++;
        if (re16 !== 1'b1 || st16 !== 2'd1) begin
          errors++;
          $display("FAIL periodic_arm: got re=%b st=%0d want re=1 st=1", re16, st16);
        end
      end
    end
  endtask

  // WIDTH=8: pwm_in is held high after one rise. The timeout fires 255 steps
  // after the risingEdge strobe and the earlier 10/3 capture is kept.
  task automatic test_timeout();
    logic exp_to;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (st8 !== 2'd0 || cv8 !== 1'b0 || to8 !== 1'b0) begin
      errors++;
      $display("FAIL disable_idle: got st=%0d cv=%b to=%b want 0 0 0", st8, cv8, to8);
    end
    repeat (2) step(1'b0, 1'b1, 1'b0);
    for (int s = 0; s <= 260; s++) begin
      step(1'b1, 1'b1, 1'b0);
      exp_to = (s == 257);
      checks++;
      if (to8 !== exp_to || cv8 !== 1'b0 || to16 !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse step %0d: got to8=%b cv8=%b to16=%b want %b 0 0",
                 s, to8, cv8, to16, exp_to);
      end
      if (s == 257) begin
        checks++;
        if (st8 !== 2'd0 || period8 !== 8'd10 || high8 !== 8'd3) begin
          errors++;
          $display("FAIL timeout_hold: got st=%0d %0d/%0d want 0 10/3", st8, period8, high8);
        end
      end
    end
    checks++;
    if (st16 !== 2'd1 || st8 !== 2'd0) begin
      errors++;
      $display("FAIL timeout_states: got %0d/%0d want 1/0", st16, st8);
    end
  endtask

  task automatic test_sync_latency();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (lvl16 !== 1'b0 || re16 !== 1'b0) begin
      errors++;
      $display("FAIL sync_step0: got lvl=%b re=%b want 0 0", lvl16, re16);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (lvl16 !== 1'b1 || re16 !== 1'b0) begin
      errors++;
      $display("FAIL sync_step1: got lvl=%b re=%b want 1 0", lvl16, re16);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (lvl16 !== 1'b1 || re16 !== 1'b1 || fe16 !== 1'b0) begin
      errors++;
      $display("FAIL sync_step2: got lvl=%b re=%b fe=%b want 1 1 0", lvl16, re16, fe16);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (lvl16 !== 1'b1 || re16 !== 1'b0) begin
      errors++;
      $display("FAIL sync_step3: got lvl=%b re=%b want 1 0", lvl16, re16);
    end
  endtask

  // enable is low for steps 4..8, in the middle of HIGH. A 20/8 waveform starts
  // at step 20, so the captures come after steps 42 and 62.
  task automatic test_enable_drop();
    logic lvl, en, exp_cv;
    do_reset();
    for (int s = 0; s <= 62; s++) begin
      if (s < 8)       lvl = 1'b1;
      else if (s < 20) lvl = 1'b0;
      else             lvl = ((s - 20) % 20) < 8;
      en = !(s >= 4 && s < 9);
      step(lvl, en, 1'b0);
      exp_cv = (s == 42) || (s == 62);
      checks++;
      if (cv16 !== exp_cv || to16 !== 1'b0) begin
        errors++;
        $display("FAIL enable_valid step %0d: got cv=%b to=%b want %b 0", s, cv16, to16, exp_cv);
      end
      if (exp_cv) begin
        checks++;
        if (period16 !== 16'd20 || high16 !== 16'd8) begin
          errors++;
          $display("FAIL enable_values step %0d: got %0d/%0d want 20/8", s, period16, high16);
        end
      end
      if (s == 3 || s == 5) begin
        checks++;
        if (st16 !== ((s == 3) ? 2'd1 : 2'd0)) begin
          errors++;
          $display("FAIL enable_state step %0d: got %0d want %0d", s, st16, (s == 3) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_narrow_pulse();
    logic exp_cv, exp_fe;
    do_reset();
    for (int s = 0; s < 18; s++) begin
      step((s % 4) == 0, 1'b1, 1'b0);
      exp_cv = (s >= 6) && ((s % 4) == 2);
      exp_fe = (s >= 3) && ((s % 4) == 3);
      checks++;
      if (cv16 !== exp_cv || fe16 !== exp_fe) begin
        errors++;
        $display("FAIL narrow_strobe step %0d: got cv=%b fe=%b want %b %b", s, cv16, fe16, exp_cv, exp_fe);
      end
      if (exp_cv) begin
        checks++;
        if (period16 !== 16'd4 || high16 !== 16'd1) begin
          errors++;
          $display("FAIL narrow_values step %0d: got %0d/%0d want 4/1", s, period16, high16);
        end
      end
    end
  endtask

  // rst is pulsed in step 16, while in LOW. The rise at step 20 only arms, and
  // the rise at step 30 captures after step 32.
  task automatic test_reset_mid_low();
    logic exp_cv;
    do_reset();
    for (int s = 0; s < 36; s++) begin
      step((s % 10) < 3, 1'b1, s == 16);
      exp_cv = (s == 12) || (s == 32);
      checks++;
      if (cv16 !== exp_cv) begin
        errors++;
        $display("FAIL rstlow_valid step %0d: got %b want %b", s, cv16, exp_cv);
      end
      if (s == 15) begin
        checks++;
        if (st16 !== 2'd2) begin
          errors++;
          $display("FAIL rstlow_prestate: got %0d want 2", st16);
        end
      end
      if (s == 16) begin
        checks++;
        if (period16 !== 16'd0 || high16 !== 16'd0 || {to16, re16, fe16, lvl16} !== 4'b0 || st16 !== 2'd0) begin
          errors++;
          $display("FAIL rstlow_cleared: got %0d/%0d %b st=%0d want 0/0 0000 st=0",
                   period16, high16, {to16, re16, fe16, lvl16}, st16);
        end
      end
      if (s == 22) begin
        checks++;
        if (period16 !== 16'd0 || st16 !== 2'd1) begin
          errors++;
          $display("FAIL rstlow_arm: got period=%0d st=%0d want 0 1", period16, st16);
        end
      end
      if (s == 32) begin
        checks++;
        if (period16 !== 16'd10 || high16 !== 16'd3) begin
          errors++;
          $display("FAIL rstlow_values: got %0d/%0d want 10/3", period16, high16);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_timeout();
    test_sync_latency();
    test_enable_drop();
    test_narrow_pulse();
    test_reset_mid_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
